// File: rtl/mem_pkg.sv
// Shared size codes, FSM state encoding and alignment rule for the MEM-stage access controller.
package mem_pkg;

    localparam int NBITS     = 32;
    localparam int HWORDBITS = 16;
    localparam int BYTENBITS = 8;
    localparam int TNBITS    = 2;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_INV  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // Word needs 4-byte alignment, half needs 2-byte, byte is always fine.
    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size_e'(size))
            SZ_WORD: ok = (addr_lo == 2'b00);
            SZ_HALF: ok = ~addr_lo[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_lane_extend.sv
// Picks the addressed byte/halfword lane out of a read word and sign/zero extends it.
// Purely combinational; word accesses pass through untouched.
module load_lane_extend
    import mem_pkg::*;
#(
    parameter int NBITS     = mem_pkg::NBITS,
    parameter int HWORDBITS = mem_pkg::HWORDBITS,
    parameter int BYTENBITS = mem_pkg::BYTENBITS,
    parameter int TNBITS    = mem_pkg::TNBITS
) (
    input  logic [1:0]        i_addr_lo,
    input  logic [TNBITS-1:0] i_size,
    input  logic              i_cero,
    input  logic [NBITS-1:0]  i_rdata,
    output logic [NBITS-1:0]  o_data
);

    logic [BYTENBITS-1:0] byte_lane;
    logic [HWORDBITS-1:0] half_lane;

    always_comb begin
        byte_lane = i_rdata[{i_addr_lo, 3'b000} +: BYTENBITS];
        half_lane = i_rdata[{i_addr_lo[1], 4'b0000} +: HWORDBITS];
        case (size_e'(i_size))
            SZ_BYTE: o_data = {{(NBITS-BYTENBITS){byte_lane[BYTENBITS-1] & ~i_cero}}, byte_lane};
            SZ_HALF: o_data = {{(NBITS-HWORDBITS){half_lane[HWORDBITS-1] & ~i_cero}}, half_lane};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: req/ack handshake to data memory, alignment check,
// store lane steering and load extension. Stalls upstream while an access is pending.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int NBITS     = mem_pkg::NBITS,
    parameter int HWORDBITS = mem_pkg::HWORDBITS,
    parameter int BYTENBITS = mem_pkg::BYTENBITS,
    parameter int TNBITS    = mem_pkg::TNBITS,
    parameter int TIMEOUT   = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_we,
    input  logic [NBITS-1:0]  i_addr,
    input  logic [TNBITS-1:0] i_size,
    input  logic              i_cero,
    input  logic [NBITS-1:0]  i_wdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [NBITS-1:0]  o_mem_addr,
    output logic [3:0]        o_mem_wstrb,
    output logic [NBITS-1:0]  o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [NBITS-1:0]  i_mem_rdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [NBITS-1:0]  o_rdata,
    output logic              o_error
);

    localparam int              CNTW     = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [NBITS-1:0]    addr_q, addr_d;
    logic [TNBITS-1:0]   size_q, size_d;
    logic                cero_q, cero_d;
    logic [NBITS-1:0]    wdata_q, wdata_d;
    logic [NBITS-1:0]    rdata_q, rdata_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;

    logic [CNTW-1:0]     cnt_inc;
    logic                req_legal;
    logic [NBITS-1:0]    load_ext;
    logic [3:0]          lane_wstrb;
    logic [NBITS-1:0]    lane_wdata;

    load_lane_extend #(
        .NBITS    (NBITS),
        .HWORDBITS(HWORDBITS),
        .BYTENBITS(BYTENBITS),
        .TNBITS   (TNBITS)
    ) u_load_lane_extend (
        .i_addr_lo(addr_q[1:0]),
        .i_size   (size_q),
        .i_cero   (cero_q),
        .i_rdata  (i_mem_rdata),
        .o_data   (load_ext)
    );

    // Store steering works off the latched request so the memory port stays stable.
    always_comb begin
        lane_wstrb = 4'b1111;
        lane_wdata = wdata_q;
        case (size_e'(size_q))
            SZ_BYTE: begin
                lane_wdata = {(NBITS/BYTENBITS){wdata_q[BYTENBITS-1:0]}};
                lane_wstrb = 4'b0001 << addr_q[1:0];
            end
            SZ_HALF: begin
                lane_wdata = {(NBITS/HWORDBITS){wdata_q[HWORDBITS-1:0]}};
                lane_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: lane_wstrb = 4'b1111;
        endcase
        if (!we_q) begin
            lane_wstrb = 4'b0000;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        size_d    = size_q;
        cero_d    = cero_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + CNTW'(1);
        req_legal = access_legal(i_size, i_addr[1:0]);
        o_mem_req = 1'b0;
        o_stall   = 1'b0;
        o_done    = 1'b0;
        o_error   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_stall = i_valid;
                cnt_d   = '0;
                if (i_valid) begin
                    we_d    = i_we;
                    addr_d  = i_addr;
                    size_d  = i_size;
                    cero_d  = i_cero;
                    wdata_d = i_wdata;
                    if (req_legal) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_ERR;
                        rdata_d = '1;
                    end
                end
            end
            ST_REQ: begin
                o_mem_req = 1'b1;
                o_stall   = 1'b1;
                // An ack in the final allowed cycle still completes normally.
                if (i_mem_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = load_ext;
                    end
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = ST_ERR;
                    rdata_d = '1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                o_done  = 1'b1;
                o_error = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            cero_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            cero_q  <= cero_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_mem_we    = o_mem_req & we_q;
    assign o_mem_addr  = o_mem_req ? {addr_q[NBITS-1:2], 2'b00} : '0;
    assign o_mem_wstrb = o_mem_req ? lane_wstrb : 4'b0000;
    assign o_mem_wdata = o_mem_req ? lane_wdata : '0;
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver pushes expected memory requests and completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        i_we;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic        i_cero;
    logic [31:0] i_wdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_error;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_size     (i_size),
        .i_cero     (i_cero),
        .i_wdata    (i_wdata),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wstrb(o_mem_wstrb),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_ack  (i_mem_ack),
        .i_mem_rdata(i_mem_rdata),
        .o_stall    (o_stall),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_error    (o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  stall;
    } done_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_exp_t;

    done_exp_t   done_q[$];
    req_exp_t    req_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the access rules.
    function automatic bit is_legal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b0;
        if (sz == 2'b00) return (a % 4) == 0;
        if (sz == 2'b10) return (a % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] load_model(input logic [1:0] sz, input logic [31:0] a,
                                               input logic cero, input logic [31:0] rd);
        logic [31:0] v;
        int          lane;
        lane = int'(a % 4);
        case (sz)
            2'b01: begin
                v = (rd >> (8 * lane)) & 32'h0000_00FF;
                if (!cero && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            2'b10: begin
                v = (rd >> (16 * (lane / 2))) & 32'h0000_FFFF;
                if (!cero && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic req_exp_t req_model(input logic we, input logic [1:0] sz,
                                           input logic [31:0] a, input logic [31:0] wd);
        req_exp_t r;
        r.addr = a - (a % 4);
        r.we   = we;
        case (sz)
            2'b01: begin
                r.wdata = (wd & 32'h0000_00FF) * 32'h0101_0101;
                r.wstrb = 4'(1 << (a % 4));
            end
            2'b10: begin
                r.wdata = (wd & 32'h0000_FFFF) * 32'h0001_0001;
                r.wstrb = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
            end
            default: begin
                r.wdata = wd;
                r.wstrb = 4'b1111;
            end
        endcase
        if (!we) r.wstrb = 4'b0000;
        return r;
    endfunction

    // d = cycle of REQ on which ack arrives (1..TIMEOUT); 0 means never.
    task automatic do_access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                             input logic cero, input logic [31:0] wd, input logic [31:0] rd,
                             input int d);
        done_exp_t e;
        bit        ok;
        ok = is_legal(sz, a);
        if (ok) begin
            req_q.push_back(req_model(we, sz, a, wd));
            if (d >= 1 && d <= TIMEOUT) begin
                e.err = 1'b0;
                if (!we) model_rdata = load_model(sz, a, cero, rd);
                e.stall = 8'(1 + d);
            end else begin
                e.err       = 1'b1;
                model_rdata = 32'hFFFF_FFFF;
                e.stall     = 8'(1 + TIMEOUT);
            end
        end else begin
            e.err       = 1'b1;
            model_rdata = 32'hFFFF_FFFF;
            e.stall     = 8'd1;
        end
        e.rdata = model_rdata;
        done_q.push_back(e);

        i_valid = 1'b1;
        i_we    = we;
        i_addr  = a;
        i_size  = sz;
        i_cero  = cero;
        i_wdata = wd;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_addr  = $urandom;
        i_wdata = $urandom;
        if (ok) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                if (k == d) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = rd;
                end else begin
                    i_mem_rdata = $urandom;
                end
                @(posedge i_clk); #1;
                i_mem_ack = 1'b0;
                if (k == d) break;
            end
        end
        @(posedge i_clk); #1;
    endtask

    task automatic run_random(input int n);
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        int          d;
        for (int i = 0; i < n; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'h0000_0400 + 32'($urandom_range(0, 63));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      d = 0;
            else if (r == 1) d = TIMEOUT;
            else             d = int'($urandom_range(1, 5));
            do_access(1'($urandom), sz, a, 1'($urandom), $urandom, $urandom, d);
        end
    endtask

    // Monitor: compares memory-side requests and completions against the queues.
    initial begin
        req_exp_t  cur;
        done_exp_t e;
        bit        req_active;
        int        stall_cnt;
        req_active = 1'b0;
        stall_cnt  = 0;
        cur        = '0;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                req_active = 1'b0;
                stall_cnt  = 0;
            end else begin
                if (o_stall) stall_cnt++;
                if (o_mem_req) begin
                    if (!req_active) begin
                        if (req_q.size() == 0) begin
                            check("unexpected_mem_req", 32'(o_mem_req), 32'h0);
                        end else begin
                            cur = req_q.pop_front();
                        end
                        req_active = 1'b1;
                    end
                    check("mem_addr", o_mem_addr, cur.addr);
                    check("mem_we", 32'(o_mem_we), 32'(cur.we));
                    check("mem_wstrb", 32'(o_mem_wstrb), 32'(cur.wstrb));
                    if (cur.we) check("mem_wdata", o_mem_wdata, cur.wdata);
                end else begin
                    req_active = 1'b0;
                end
                if (o_done) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 32'(o_done), 32'h0);
                    end else begin
                        e = done_q.pop_front();
                        check("done_error", 32'(o_error), 32'(e.err));
                        check("done_rdata", o_rdata, e.rdata);
                        check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    end
                    stall_cnt = 0;
                end else begin
                    check("error_without_done", 32'(o_error), 32'h0);
                end
            end
        end
    end

    initial begin
        i_reset     = 1'b1;
        i_valid     = 1'b0;
        i_we        = 1'b0;
        i_addr      = 32'h0;
        i_size      = 2'b00;
        i_cero      = 1'b0;
        i_wdata     = 32'h0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        #2;
        check("reset_mem_req", 32'(o_mem_req), 32'h0);
        check("reset_done", 32'(o_done), 32'h0);
        check("reset_error", 32'(o_error), 32'h0);
        check("reset_stall", 32'(o_stall), 32'h0);
        check("reset_rdata", o_rdata, 32'h0);
        check("reset_mem_addr", o_mem_addr, 32'h0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        do_access(1'b0, 2'b01, 32'h0000_0103, 1'b1, 32'h0, 32'h80FF_1234, 2);
        do_access(1'b0, 2'b10, 32'h0000_0102, 1'b0, 32'h0, 32'h8001_7FFF, 1);
        do_access(1'b0, 2'b10, 32'h0000_0100, 1'b0, 32'h0, 32'h8001_7FFF, 1);
        do_access(1'b1, 2'b01, 32'h0000_0201, 1'b0, 32'h0000_00AB, 32'h0, 3);
        do_access(1'b1, 2'b10, 32'h0000_0202, 1'b0, 32'h1234_BEEF, 32'h0, 1);
        do_access(1'b1, 2'b00, 32'h0000_0204, 1'b0, 32'hCAFE_F00D, 32'h0, 2);
        do_access(1'b0, 2'b00, 32'h0000_0102, 1'b0, 32'h0, 32'h0, 1);
        do_access(1'b0, 2'b11, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 1);
        do_access(1'b0, 2'b00, 32'h0000_0108, 1'b0, 32'h0, 32'h5555_AAAA, 0);
        do_access(1'b0, 2'b00, 32'h0000_010C, 1'b0, 32'h0, 32'h1357_9BDF, TIMEOUT);
        do_access(1'b1, 2'b00, 32'h0000_0110, 1'b0, 32'h0BAD_0BAD, 32'h0, 1);

        // Reset while the request is outstanding; the late ack must be ignored.
        req_q.push_back(req_model(1'b0, 2'b00, 32'h0000_0300, 32'h0));
        i_valid = 1'b1;
        i_we    = 1'b0;
        i_addr  = 32'h0000_0300;
        i_size  = 2'b00;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        check("req_before_reset", 32'(o_mem_req), 32'h1);
        i_reset = 1'b1;
        #1;
        check("reset_drops_req", 32'(o_mem_req), 32'h0);
        check("reset_drops_stall", 32'(o_stall), 32'h0);
        check("reset_clears_rdata", o_rdata, 32'h0);
        model_rdata = 32'h0;
        @(posedge i_clk); #1;
        i_reset     = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hDEAD_BEEF;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("no_done_after_reset", 32'(o_done), 32'h0);
            check("no_req_after_reset", 32'(o_mem_req), 32'h0);
            @(posedge i_clk); #1;
        end

        do_access(1'b1, 2'b01, 32'h0000_0203, 1'b0, 32'h0000_0011, 32'h0, 1);
        run_random(80);

        repeat (4) @(posedge i_clk);
        #1;
        check("pending_done", 32'(done_q.size()), 32'h0);
        check("pending_req", 32'(req_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
